// File: rtl/mont_operand_streamer_if.sv
// Operand/result bus between the host-side streamer and its controller.
// The slave modport is the streamer's view; master is the host/bench view.
interface mont_operand_streamer_if #(
  parameter int unsigned WORD = 64,
  parameter int unsigned OPW  = 1024,
  parameter int unsigned TW   = 32
);
  logic            i_start;
  logic [OPW-1:0]  i_op_u;
  logic [OPW-1:0]  i_op_v;
  logic            i_core_flag;
  logic            o_ready;
  logic            o_core_rst;
  logic [WORD-1:0] o_bus_out;
  logic            o_bus_valid;
  logic            o_done;
  logic            o_pass;
  logic            o_timeout;
  logic [TW-1:0]   o_cycles;

  modport slave (
    input  i_start, i_op_u, i_op_v, i_core_flag,
    output o_ready, o_core_rst, o_bus_out, o_bus_valid, o_done, o_pass, o_timeout, o_cycles
  );

  modport master (
    output i_start, i_op_u, i_op_v, i_core_flag,
    input  o_ready, o_core_rst, o_bus_out, o_bus_valid, o_done, o_pass, o_timeout, o_cycles
  );
endinterface

// File: rtl/mont_operand_streamer.sv
// Resets the Montgomery core, streams u then v one word per cycle (LS word first),
// then waits for the core's pass flag with a timeout and reports the outcome.
module mont_operand_streamer #(
  parameter int unsigned WORD       = 64,
  parameter int unsigned OPW        = 1024,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 2000000,
  parameter int unsigned TW         = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  mont_operand_streamer_if.slave    bus
);
  localparam int unsigned BEATS = OPW / WORD;
  localparam int unsigned BW    = $clog2(2 * BEATS);
  localparam logic [BW-1:0] LastBeat = BW'(2 * BEATS - 1);
  localparam logic [TW-1:0] RstLast  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] WaitLast = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] WaitMax  = TW'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StCrst, StSend, StWait, StDone} state_e;

  state_e            r_state;
  logic [2*OPW-1:0]  r_ops;
  logic [TW-1:0]     r_cnt;
  logic [BW-1:0]     r_beat;
  logic              r_ready;
  logic              r_core_rst;
  logic [WORD-1:0]   r_bus_out;
  logic              r_bus_valid;
  logic              r_done;
  logic              r_pass;
  logic              r_timeout;
  logic [TW-1:0]     r_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_ops       <= '0;
      r_cnt       <= '0;
      r_beat      <= '0;
      r_ready     <= 1'b1;
      r_core_rst  <= 1'b1;
      r_bus_out   <= '0;
      r_bus_valid <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_cycles    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (bus.i_start && r_ready) begin
            // u occupies the low half so a plain right shift yields u words then v words.
            r_ops      <= {bus.i_op_v, bus.i_op_u};
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_cycles   <= '0;
            r_cnt      <= '0;
            r_core_rst <= 1'b1;
            r_ready    <= 1'b0;
            r_state    <= StCrst;
          end
        end
        StCrst: begin
          if (r_cnt == RstLast) begin
            r_core_rst  <= 1'b0;
            r_bus_out   <= r_ops[WORD-1:0];
            r_bus_valid <= 1'b1;
            r_beat      <= '0;
            r_state     <= StSend;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StSend: begin
          if (r_beat == LastBeat) begin
            r_bus_out   <= '0;
            r_bus_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= StWait;
          end else begin
            r_beat    <= r_beat + 1'b1;
            r_bus_out <= r_ops[WORD +: WORD];
            r_ops     <= {{WORD{1'b0}}, r_ops[2*OPW-1:WORD]};
          end
        end
        StWait: begin
          // The flag is checked first so a pass on the final allowed cycle beats the timeout.
          if (bus.i_core_flag) begin
            r_pass   <= 1'b1;
            r_cycles <= r_cnt;
            r_done   <= 1'b1;
            r_ready  <= 1'b1;
            r_state  <= StDone;
          end else if (r_cnt == WaitLast) begin
            r_timeout <= 1'b1;
            r_cycles  <= WaitMax;
            r_done    <= 1'b1;
            r_ready   <= 1'b1;
            r_state   <= StDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.o_ready     = r_ready;
  assign bus.o_core_rst  = r_core_rst;
  assign bus.o_bus_out   = r_bus_out;
  assign bus.o_bus_valid = r_bus_valid;
  assign bus.o_done      = r_done;
  assign bus.o_pass      = r_pass;
  assign bus.o_timeout   = r_timeout;
  assign bus.o_cycles    = r_cycles;
endmodule
